// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the RAM port arbiter
package ram_arb_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Remembers who was granted last cycle so the RAM read data is routed back to them.
    typedef struct packed {
        owner_e owner;
        logic   err;
        logic   we;
    } rsp_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - fetch, data and RAM-side signal bundle of the arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int NB_COL = 4
);
    logic              hold_i;
    logic              if_req_valid_i;
    logic [31:0]       if_req_addr_i;
    logic              if_req_ready_o;
    logic              if_rsp_valid_o;
    logic [DATA_W-1:0] if_rsp_data_o;
    logic              if_rsp_err_o;
    logic              dm_req_valid_i;
    logic              dm_req_we_i;
    logic [31:0]       dm_req_addr_i;
    logic [DATA_W-1:0] dm_req_wdata_i;
    logic [NB_COL-1:0] dm_req_strb_i;
    logic              dm_req_ready_o;
    logic              dm_rsp_valid_o;
    logic [DATA_W-1:0] dm_rsp_data_o;
    logic              dm_rsp_err_o;
    logic              ram_rd_en_o;
    logic [ADDR_W-1:0] ram_rd_addr_o;
    logic [ADDR_W-1:0] ram_wr_addr_o;
    logic [DATA_W-1:0] ram_wr_data_o;
    logic [NB_COL-1:0] ram_wr_strb_o;
    logic [DATA_W-1:0] ram_rd_data_i;

    modport slave (
        input  hold_i, if_req_valid_i, if_req_addr_i,
        input  dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i, dm_req_strb_i,
        input  ram_rd_data_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
        output dm_req_ready_o, dm_rsp_valid_o, dm_rsp_data_o, dm_rsp_err_o,
        output ram_rd_en_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_strb_o
    );

    modport master (
        output hold_i, if_req_valid_i, if_req_addr_i,
        output dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i, dm_req_strb_i,
        output ram_rd_data_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
        input  dm_req_ready_o, dm_rsp_valid_o, dm_rsp_data_o, dm_rsp_err_o,
        input  ram_rd_en_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_strb_o
    );
endinterface

// File: rtl/ram_addr_decode.sv
// rtl/ram_addr_decode.sv - byte address to RAM word index with range check
module ram_addr_decode
    import ram_arb_pkg::*;
#(
    parameter int          ADDR_W   = 17,
    parameter logic [31:0] RAM_BASE = RAM_BASE_DEFAULT
) (
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] idx,
    output logic              in_range
);
    logic [31:0] offset;

    assign offset   = addr - RAM_BASE;
    // Byte lane bits drop out here; the index is purely the word offset.
    assign idx      = offset[ADDR_W+1:2];
    assign in_range = (addr >= RAM_BASE) && ((offset >> (ADDR_W + 2)) == 32'd0);
endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM shared by fetch and data, data-first with anti-starvation
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          ADDR_W       = 17,
    parameter int          DATA_W       = 32,
    parameter int          NB_COL       = 4,
    parameter logic [31:0] RAM_BASE     = RAM_BASE_DEFAULT,
    parameter int          STARVE_LIMIT = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    ram_port_arbiter_if.slave bus
);
    localparam int            SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    rsp_tag_t          tag_q, tag_d;
    logic [ADDR_W-1:0] if_idx, dm_idx;
    logic              if_in, dm_in;
    logic              can_grant, fetch_first, if_grant, dm_grant;

    ram_addr_decode #(.ADDR_W(ADDR_W), .RAM_BASE(RAM_BASE)) u_if_dec (
        .addr     (bus.if_req_addr_i),
        .idx      (if_idx),
        .in_range (if_in)
    );

    ram_addr_decode #(.ADDR_W(ADDR_W), .RAM_BASE(RAM_BASE)) u_dm_dec (
        .addr     (bus.dm_req_addr_i),
        .idx      (dm_idx),
        .in_range (dm_in)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            starve_q <= '0;
            tag_q    <= '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (bus.hold_i)  state_d = ST_HOLD;
            ST_HOLD: if (!bus.hold_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Gating on rst_ni keeps RAM strobes quiet while reset is held.
    assign can_grant   = rst_ni && (state_q == ST_RUN) && !bus.hold_i;
    assign fetch_first = (starve_q == STARVE_MAX);
    assign if_grant    = can_grant && bus.if_req_valid_i && (fetch_first || !bus.dm_req_valid_i);
    assign dm_grant    = can_grant && bus.dm_req_valid_i && !(fetch_first && bus.if_req_valid_i);

    always_comb begin
        starve_d = '0;
        if (bus.if_req_valid_i && !if_grant)
            starve_d = fetch_first ? STARVE_MAX : starve_q + SC_W'(1);
    end

    always_comb begin
        tag_d = '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
        if (if_grant) begin
            tag_d = '{owner: OWN_IF, err: !if_in, we: 1'b0};
        end else if (dm_grant) begin
            tag_d = '{owner: OWN_DM, err: !dm_in, we: bus.dm_req_we_i};
        end
    end

    assign bus.if_req_ready_o = if_grant;
    assign bus.dm_req_ready_o = dm_grant;

    assign bus.ram_rd_en_o   = (if_grant && if_in) || (dm_grant && dm_in && !bus.dm_req_we_i);
    assign bus.ram_rd_addr_o = if_grant ? if_idx : dm_idx;
    assign bus.ram_wr_addr_o = dm_idx;
    assign bus.ram_wr_data_o = bus.dm_req_wdata_i;
    assign bus.ram_wr_strb_o = (dm_grant && dm_in && bus.dm_req_we_i) ? bus.dm_req_strb_i
                                                                       : {NB_COL{1'b0}};

    assign bus.if_rsp_valid_o = (tag_q.owner == OWN_IF);
    assign bus.if_rsp_err_o   = (tag_q.owner == OWN_IF) && tag_q.err;
    assign bus.if_rsp_data_o  = ((tag_q.owner == OWN_IF) && !tag_q.err)
                                ? bus.ram_rd_data_i : {DATA_W{1'b0}};

    assign bus.dm_rsp_valid_o = (tag_q.owner == OWN_DM);
    assign bus.dm_rsp_err_o   = (tag_q.owner == OWN_DM) && tag_q.err;
    assign bus.dm_rsp_data_o  = ((tag_q.owner == OWN_DM) && !tag_q.err && !tag_q.we)
                                ? bus.ram_rd_data_i : {DATA_W{1'b0}};
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- ADDR_W, 17, RAM word-index width.
- DATA_W, 32, data width.
- NB_COL, 4, byte strobes.
- RAM_BASE, 32'h8000_0000, byte address of RAM word 0.
- STARVE_LIMIT, 4, consecutive fetch denials before forced fetch grant.

REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- hold_i, in, 1, RAM programming in progress; block new grants.
- if_req_valid_i, in, 1, fetch read request.
- if_req_addr_i, in, 32, fetch byte address.
- if_req_ready_o, out, 1, fetch request accepted this cycle.
- if_rsp_valid_o, out, 1, fetch response.
- if_rsp_data_o, out, DATA_W, fetch read data.
- if_rsp_err_o, out, 1, fetch address out of range.
- dm_req_valid_i, in, 1, data request.
- dm_req_we_i, in, 1, 1 = write.
- dm_req_addr_i, in, 32, data byte address.
- dm_req_wdata_i, in, DATA_W, write data.
- dm_req_strb_i, in, NB_COL, write byte strobes.
- dm_req_ready_o, out, 1, data request accepted.
- dm_rsp_valid_o, out, 1, data response (read data or write ack).
- dm_rsp_data_o, out, DATA_W, read data; 0 for writes.
- dm_rsp_err_o, out, 1, data address out of range.
- ram_rd_en_o, out, 1, RAM read enable.
- ram_rd_addr_o, out, ADDR_W, RAM read word index.
- ram_wr_addr_o, out, ADDR_W, RAM write word index.
- ram_wr_data_o, out, DATA_W, RAM write data.
- ram_wr_strb_o, out, NB_COL, RAM byte write enables.
- ram_rd_data_i, in, DATA_W, RAM registered read data (1-cycle latency).

Function
REQ-003 The block SHALL accept at most one request per cycle; acceptance = valid && ready; readies combinational from valids, state and starve counter.
REQ-004 State machine SHALL have RUN and HOLD; RUN->HOLD when hold_i=1, HOLD->RUN the cycle after hold_i=0.
REQ-005 In HOLD both readies, ram_rd_en_o and ram_wr_strb_o SHALL be 0.
REQ-006 In RUN, data port SHALL win when both are valid, unless starve_cnt == STARVE_LIMIT, then fetch SHALL win.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle fetch is valid and not granted, and clear on fetch grant or fetch not valid.
REQ-008 Word index SHALL be (addr - RAM_BASE) >> 2; in range iff addr >= RAM_BASE and index < 2^ADDR_W; addr[1:0] SHALL be ignored.
REQ-009 Accepted in-range reads SHALL assert ram_rd_en_o with the index in the acceptance cycle.
REQ-010 Accepted in-range writes SHALL drive ram_wr_addr_o, ram_wr_data_o and ram_wr_strb_o = dm_req_strb_i in the acceptance cycle; ram_wr_strb_o SHALL be 0 otherwise.
REQ-011 Out-of-range requests SHALL still be accepted but SHALL NOT touch RAM.
REQ-012 A registered owner tag (NONE/IF/DM, plus err, we) SHALL route exactly one response, one cycle after acceptance, to the accepting port.
- rsp_data = ram_rd_data_i for reads.
- rsp_data = 0 for writes and errors.
- err = 1 on out-of-range.
REQ-013 There SHALL be no response backpressure; rsp_valid SHALL be a single-cycle pulse.
REQ-014 A response owed for the cycle before hold_i rises SHALL still be delivered.
REQ-015 Write followed by read of the same index on the next cycle SHALL return the new data.

Reset
REQ-016 While rst_ni=0, registers SHALL clear asynchronously: state=RUN, starve_cnt=0, owner=NONE. All rsp_valid/err, ram_rd_en_o and ram_wr_strb_o SHALL be 0.
REQ-017 A response pending at reset assertion SHALL be discarded.

Structure
REQ-018 Owner-tag encoding, state encoding and RAM_BASE default SHALL live in the shared package ram_arb_pkg.
REQ-019 The address range check SHALL be a sub-module ram_addr_decode, instantiated once per port.

Verification
REQ-020 Fetch read 0x8000_0010 with RAM word 4 = 0xDEADBEEF -> if_req_ready_o=1 same cycle; if_rsp_valid_o=1 and if_rsp_data_o=0xDEADBEEF next cycle.
REQ-021 Both ports valid continuously -> data port granted 4 cycles, fetch granted on the 5th, pattern repeats.
REQ-022 Data write 0x8000_0008, wdata 0x11223344, strb 4'b0011, then read same address -> ack with data 0; read returns old[31:16] with 0x3344 in the low half.
REQ-023 Fetch 0x7FFF_FFFC and data 0x8008_0000 -> err=1, data 0, no ram_rd_en_o or ram_wr_strb_o pulse.
REQ-024 hold_i raised the cycle after a fetch acceptance -> response still delivered; no readies while held; grants resume the cycle after hold_i falls.
REQ-025 rst_ni low mid-response -> rsp_valid drops immediately; after release state=RUN and starve_cnt=0.
